// File: rtl/joypad_pkg.sv
// joypad_pkg: button ordering, default keymap and bus constants for joypad_ctrl.
// Rev 1.0
`default_nettype none

package joypad_pkg;

  typedef enum logic [2:0] {
    BTN_A      = 3'd0,
    BTN_B      = 3'd1,
    BTN_SELECT = 3'd2,
    BTN_START  = 3'd3,
    BTN_UP     = 3'd4,
    BTN_DOWN   = 3'd5,
    BTN_LEFT   = 3'd6,
    BTN_RIGHT  = 3'd7
  } btn_e;

  localparam int KEY_TURBO_A = 8;
  localparam int KEY_TURBO_B = 9;

  localparam logic [7:0] SIG_P0   = 8'h10;
  localparam logic [7:0] SIG_P1   = 8'h20;
  localparam logic [7:0] OPEN_BUS = 8'h40;

  // PS/2 set-2 codes: A, B, Select, Start, Up, Down, Left, Right, turbo-A, turbo-B
  localparam logic [7:0] KEYMAP [4][10] = '{
    '{8'h22, 8'h1A, 8'h59, 8'h5A, 8'h75, 8'h72, 8'h6B, 8'h74, 8'h1B, 8'h1C},
    '{8'h42, 8'h3B, 8'h31, 8'h3A, 8'h43, 8'h4B, 8'h3C, 8'h4D, 8'h44, 8'h33},
    '{8'h15, 8'h1D, 8'h24, 8'h2D, 8'h2C, 8'h35, 8'h23, 8'h2B, 8'h34, 8'h21},
    '{8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46, 8'h45}
  };

endpackage

`default_nettype wire

// File: rtl/joypad_shifter.sv
// joypad_shifter: per-port serial shift register, LSB out first, fills with 1s.
// Rev 1.0
`default_nettype none

module joypad_shifter #(
  parameter int           L       = 8,
  parameter logic [L-1:0] RST_VAL = '0
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         i_load,
  input  logic [L-1:0] i_load_data,
  input  logic         i_shift,
  output logic         o_head
);

  logic [L-1:0] r_sr;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_sr <= RST_VAL;
    end else if (i_load) begin
      r_sr <= i_load_data;
    end else if (i_shift) begin
      r_sr <= {1'b1, r_sr[L-1:1]};
    end
  end

  assign o_head = r_sr[0];

endmodule

`default_nettype wire

// File: rtl/joypad_ctrl.sv
// joypad_ctrl: $4016/$4017 controller ports fed by PS/2 key events, 1-4 pads,
// Four Score streams and frame-locked turbo. Rev 1.0
`default_nettype none

module joypad_ctrl
  import joypad_pkg::*;
#(
  parameter int NUM_PADS     = 2,
  parameter bit TURBO_EN     = 1'b1,
  parameter int TURBO_FRAMES = 2
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  i_key_valid,
  input  logic [7:0]            i_key_code,
  input  logic                  i_key_press,
  input  logic                  i_frame_tick,
  input  logic                  i_bus_en,
  input  logic                  i_bus_rw,
  input  logic                  i_bus_port,
  input  logic [7:0]            i_bus_wdata,
  output logic [7:0]            o_bus_rdata,
  output logic [NUM_PADS*8-1:0] o_pad_state
);

  localparam int L   = (NUM_PADS > 2) ? 24 : 8;
  localparam int FCW = (TURBO_FRAMES > 1) ? $clog2(TURBO_FRAMES) : 1;

  localparam logic [23:0]  c_RST0_FULL = {SIG_P0, 16'h0000};
  localparam logic [23:0]  c_RST1_FULL = {SIG_P1, 16'h0000};
  localparam logic [L-1:0] c_RST0      = c_RST0_FULL[L-1:0];
  localparam logic [L-1:0] c_RST1      = c_RST1_FULL[L-1:0];

  logic           r_phase, w_phase_nxt;
  logic [FCW-1:0] r_frame_cnt, w_frame_cnt_nxt;
  logic           r_strobe, w_strobe_nxt;
  logic [3:0][7:0] w_eff, w_eff_nxt;

  always_comb begin
    w_phase_nxt     = r_phase;
    w_frame_cnt_nxt = r_frame_cnt;
    if (i_frame_tick) begin
      if (r_frame_cnt == FCW'(TURBO_FRAMES - 1)) begin
        w_frame_cnt_nxt = '0;
        w_phase_nxt     = ~r_phase;
      end else begin
        w_frame_cnt_nxt = r_frame_cnt + FCW'(1);
      end
    end
  end

  // Shift registers load from next-state so same-cycle key events are captured.
  for (genvar p = 0; p < 4; p++) begin : g_pad
    if (p < NUM_PADS) begin : g_on
      logic [7:0] r_held, w_held_nxt;
      logic [1:0] r_turbo, w_turbo_nxt;

      always_comb begin
        w_held_nxt  = r_held;
        w_turbo_nxt = r_turbo;
        if (i_key_valid) begin
          for (int b = 0; b < 8; b++) begin
            if (i_key_code == KEYMAP[p][b]) w_held_nxt[b] = i_key_press;
          end
          if (TURBO_EN) begin
            if (i_key_code == KEYMAP[p][KEY_TURBO_A]) w_turbo_nxt[0] = i_key_press;
            if (i_key_code == KEYMAP[p][KEY_TURBO_B]) w_turbo_nxt[1] = i_key_press;
          end
        end
      end

      always_ff @(posedge clk) begin
        if (!reset_n) begin
          r_held  <= '0;
          r_turbo <= '0;
        end else begin
          r_held  <= w_held_nxt;
          r_turbo <= w_turbo_nxt;
        end
      end

      assign w_eff[p]     = r_held | {6'b0, r_turbo & {2{r_phase}}};
      assign w_eff_nxt[p] = w_held_nxt | {6'b0, w_turbo_nxt & {2{w_phase_nxt}}};
      assign o_pad_state[p*8 +: 8] = w_eff[p];
    end else begin : g_off
      assign w_eff[p]     = 8'h00;
      assign w_eff_nxt[p] = 8'h00;
    end
  end

  logic w_wr4016, w_load, w_rd, w_head0, w_head1;
  logic [L-1:0] w_img0, w_img1;

  assign w_wr4016     = i_bus_en & ~i_bus_rw & ~i_bus_port;
  assign w_strobe_nxt = w_wr4016 ? i_bus_wdata[0] : r_strobe;
  assign w_load       = r_strobe | w_strobe_nxt;
  assign w_rd         = i_bus_en & i_bus_rw & ~r_strobe;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_phase     <= 1'b0;
      r_frame_cnt <= '0;
      r_strobe    <= 1'b0;
    end else begin
      r_phase     <= w_phase_nxt;
      r_frame_cnt <= w_frame_cnt_nxt;
      r_strobe    <= w_strobe_nxt;
    end
  end

  if (L == 8) begin : g_std
    assign w_img0 = w_eff_nxt[0];
    assign w_img1 = w_eff_nxt[1];
  end else begin : g_four_score
    assign w_img0 = {SIG_P0, w_eff_nxt[2], w_eff_nxt[0]};
    assign w_img1 = {SIG_P1, w_eff_nxt[3], w_eff_nxt[1]};
  end

  joypad_shifter #(.L(L), .RST_VAL(c_RST0)) u_port0 (
    .clk         (clk),
    .reset_n     (reset_n),
    .i_load      (w_load),
    .i_load_data (w_img0),
    .i_shift     (w_rd & ~i_bus_port),
    .o_head      (w_head0)
  );

  joypad_shifter #(.L(L), .RST_VAL(c_RST1)) u_port1 (
    .clk         (clk),
    .reset_n     (reset_n),
    .i_load      (w_load),
    .i_load_data (w_img1),
    .i_shift     (w_rd & i_bus_port),
    .o_head      (w_head1)
  );

  assign o_bus_rdata = OPEN_BUS | {7'b0, (i_bus_port ? w_head1 : w_head0)};

  logic w_unused;
  assign w_unused = ^{i_bus_wdata[7:1], w_eff, w_eff_nxt};

endmodule

`default_nettype wire
